// File: rtl/uart_pkg.sv
// Shared constants, state encodings and divider helper for the DL11 serial port.
package uart_pkg;
   localparam int FRAME_BITS   = 10;
   localparam int OVERSAMPLE   = 16;
   localparam int SAMPLE_PHASE = 8;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   function automatic int div_round(input int num, input int den);
      return (num + den / 2) / den;
   endfunction
endpackage

// File: rtl/uart_brg_tick.sv
// Free-running baud dividers: one-cycle tx_tick every TX_DIV clks, rx_tick every RX_DIV clks.
module uart_brg_tick #(
   parameter int TX_DIV = 64,
   parameter int RX_DIV = 4
)(
   input  logic clk,
   input  logic reset,
   output logic tx_tick,
   output logic rx_tick
);
   localparam int TXW = $clog2(TX_DIV + 1);
   localparam int RXW = $clog2(RX_DIV + 1);
   localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
   localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

   logic [TXW-1:0] r_tx_cnt;
   logic [RXW-1:0] r_rx_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tx_cnt <= '0;
         r_rx_cnt <= '0;
      end else begin
         r_tx_cnt <= (r_tx_cnt == TX_LAST) ? '0 : r_tx_cnt + 1'b1;
         r_rx_cnt <= (r_rx_cnt == RX_LAST) ? '0 : r_rx_cnt + 1'b1;
      end
   end

   assign tx_tick = (r_tx_cnt == TX_LAST);
   assign rx_tick = (r_rx_cnt == RX_LAST);
endmodule

// File: rtl/uart_brg.sv
// 8N1 transceiver with baud generator: serial side of the DL11 console port,
// 4-phase byte handshakes toward the register block.
module uart_brg
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 9600,
   parameter int TX_DIV = div_round(CLK_HZ, BAUD),
   parameter int RX_DIV = div_round(CLK_HZ, OVERSAMPLE * BAUD)
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       ld_tx_req,
   output logic       ld_tx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_enable,
   output logic       tx_out,
   output logic       tx_empty,
   input  logic       uld_rx_req,
   output logic       uld_rx_ack,
   output logic [7:0] rx_data,
   input  logic       rx_enable,
   input  logic       rx_in,
   output logic       rx_empty
);
   localparam int         DATA_BITS = FRAME_BITS - 2;
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic [3:0] MID_PHASE = 4'(SAMPLE_PHASE - 1);

   logic w_tx_tick, w_rx_tick;

   uart_brg_tick #(.TX_DIV(TX_DIV), .RX_DIV(RX_DIV)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .tx_tick (w_tx_tick),
      .rx_tick (w_rx_tick)
   );

   // ---------------- transmitter ----------------
   tx_state_t  r_tx_state, w_tx_next;
   logic [7:0] r_tx_shift;
   logic [2:0] r_tx_bit;
   logic       r_tx_empty, r_ld_ack;
   logic       w_ld;

   assign w_ld = ld_tx_req && !r_ld_ack && r_tx_empty;

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:  if (w_tx_tick && !r_tx_empty && tx_enable) w_tx_next = TX_START;
         TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
         TX_DATA:  if (w_tx_tick && r_tx_bit == LAST_BIT) w_tx_next = TX_STOP;
         TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
         default:  w_tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) r_tx_state <= TX_IDLE;
      else        r_tx_state <= w_tx_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ld_ack   <= 1'b0;
         r_tx_empty <= 1'b1;
         r_tx_bit   <= '0;
      end else begin
         if (w_ld) begin
            r_ld_ack   <= 1'b1;
            r_tx_empty <= 1'b0;
         end else if (!ld_tx_req) begin
            r_ld_ack <= 1'b0;
         end
         if (r_tx_state == TX_STOP && w_tx_tick) r_tx_empty <= 1'b1;
         if (r_tx_state == TX_START)                    r_tx_bit <= '0;
         else if (r_tx_state == TX_DATA && w_tx_tick)   r_tx_bit <= r_tx_bit + 1'b1;
      end
   end

   // The held byte doubles as the shift register; no reload can occur until the frame ends.
   always_ff @(posedge clk) begin
      if (w_ld)                                     r_tx_shift <= tx_data;
      else if (r_tx_state == TX_DATA && w_tx_tick)  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
   end

   assign tx_out    = (r_tx_state == TX_START) ? 1'b0 :
                      (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;
   assign tx_empty  = r_tx_empty;
   assign ld_tx_ack = r_ld_ack;

   // ---------------- receiver ----------------
   rx_state_t  r_rx_state, w_rx_next;
   logic       r_rx_s1, r_rx_s2, r_rx_prev;
   logic [3:0] r_rx_phase;
   logic [2:0] r_rx_bit;
   logic [7:0] r_rx_shift, r_rx_data;
   logic       r_rx_empty, r_uld_ack;
   logic       w_rx_fall, w_rx_mid, w_rx_done;

   assign w_rx_fall = r_rx_prev && !r_rx_s2;
   assign w_rx_mid  = w_rx_tick && (r_rx_phase == MID_PHASE);
   assign w_rx_done = rx_enable && (r_rx_state == RX_STOP) && w_rx_mid && r_rx_s2;

   always_comb begin
      w_rx_next = r_rx_state;
      if (!rx_enable) begin
         w_rx_next = RX_IDLE;
      end else begin
         case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_mid)  w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_mid && r_rx_bit == LAST_BIT) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_mid)  w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) r_rx_state <= RX_IDLE;
      else        r_rx_state <= w_rx_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_phase <= '0;
         r_rx_bit   <= '0;
         r_rx_data  <= '0;
         r_rx_empty <= 1'b1;
         r_uld_ack  <= 1'b0;
      end else begin
         r_rx_s1   <= rx_in;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
         // Phase stays cleared while idle so the mid-bit point is measured from the start edge.
         if (r_rx_state == RX_IDLE) r_rx_phase <= '0;
         else if (w_rx_tick)        r_rx_phase <= r_rx_phase + 1'b1;
         if (r_rx_state == RX_START)                  r_rx_bit <= '0;
         else if (r_rx_state == RX_DATA && w_rx_mid)  r_rx_bit <= r_rx_bit + 1'b1;
         if (w_rx_done) r_rx_data <= r_rx_shift;
         if (uld_rx_req && !r_uld_ack) r_uld_ack <= 1'b1;
         else if (!uld_rx_req)         r_uld_ack <= 1'b0;
         if (w_rx_done)                     r_rx_empty <= 1'b0;
         else if (uld_rx_req && !r_uld_ack) r_rx_empty <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (r_rx_state == RX_DATA && w_rx_mid) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
   end

   assign rx_data    = r_rx_data;
   assign rx_empty   = r_rx_empty;
   assign uld_rx_ack = r_uld_ack;
endmodule

// File: tb/tb_uart_brg.sv
// Directed bench for uart_brg at 64 clks per bit (TX_DIV=64, RX_DIV=4).
module tb_uart_brg;
   localparam int BAUD   = 9600;
   localparam int CLK_HZ = 64 * BAUD;
   localparam int BITC   = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ld_tx_req = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_enable = 1'b1;
   logic       uld_rx_req = 1'b0;
   logic       rx_enable = 1'b1;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       rx_in;
   logic       ld_tx_ack, tx_out, tx_empty, uld_rx_ack, rx_empty;
   logic [7:0] rx_data;

   int n_cmp = 0;
   int n_mis = 0;
   logic [7:0] lb_bytes [3] = '{8'h00, 8'hFF, 8'h5A};

   assign rx_in = loop_en ? tx_out : rx_drv;

   uart_brg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_tx_req  (ld_tx_req),
      .ld_tx_ack  (ld_tx_ack),
      .tx_data    (tx_data),
      .tx_enable  (tx_enable),
      .tx_out     (tx_out),
      .tx_empty   (tx_empty),
      .uld_rx_req (uld_rx_req),
      .uld_rx_ack (uld_rx_ack),
      .rx_data    (rx_data),
      .rx_enable  (rx_enable),
      .rx_in      (rx_in),
      .rx_empty   (rx_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic clks(input int n);
      repeat (n) clk1();
   endtask

   task automatic load_tx(input logic [7:0] d);
      tx_data   = d;
      ld_tx_req = 1'b1;
      clk1();
      chk("ld_ack_rise", ld_tx_ack, 1);
      chk("tx_empty_load", tx_empty, 0);
      ld_tx_req = 1'b0;
      clk1();
      chk("ld_ack_fall", ld_tx_ack, 0);
   endtask

   task automatic check_tx_frame(input logic [7:0] d, input int max_wait);
      bit ok;
      logic [9:0] bits;
      ok = 1'b0;
      for (int i = 0; i < max_wait; i++) begin
         if (tx_out == 1'b0) begin
            ok = 1'b1;
            break;
         end
         clk1();
      end
      chk("tx_start_seen", ok, 1);
      clks(BITC / 2);
      for (int i = 0; i < 10; i++) begin
         bits[i] = tx_out;
         if (i < 9) clks(BITC);
      end
      chk("tx_frame", bits, {1'b1, d, 1'b0});
      clks(BITC / 2 + 1);
      chk("tx_empty_done", tx_empty, 1);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop);
      rx_drv = 1'b0;
      clks(BITC);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         clks(BITC);
      end
      rx_drv = stop;
      clks(BITC);
      rx_drv = 1'b1;
      clks(BITC);
   endtask

   task automatic unload();
      uld_rx_req = 1'b1;
      clk1();
      uld_rx_req = 1'b0;
      clk1();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int lows;
      // Reset
      reset = 1'b0;
      clks(3);
      chk("rst_tx_out", tx_out, 1);
      chk("rst_tx_empty", tx_empty, 1);
      chk("rst_rx_empty", rx_empty, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_ld_ack", ld_tx_ack, 0);
      chk("rst_uld_ack", uld_rx_ack, 0);
      reset = 1'b1;
      clk1();

      // Transmit 0x55
      load_tx(8'h55);
      check_tx_frame(8'h55, 100);

      // Receive 0xA3 and unload
      send_rx(8'hA3, 1'b1);
      chk("rx_a3_empty", rx_empty, 0);
      chk("rx_a3_data", rx_data, 8'hA3);
      uld_rx_req = 1'b1;
      clk1();
      chk("uld_ack_rise", uld_rx_ack, 1);
      chk("uld_rx_empty", rx_empty, 1);
      chk("uld_rx_data", rx_data, 8'hA3);
      uld_rx_req = 1'b0;
      clk1();
      chk("uld_ack_fall", uld_rx_ack, 0);

      // Framing error
      send_rx(8'h3C, 1'b0);
      chk("frm_empty", rx_empty, 1);
      chk("frm_data", rx_data, 8'hA3);

      // Glitch on the line
      rx_drv = 1'b0;
      clks(16);
      rx_drv = 1'b1;
      clks(200);
      chk("glitch_empty", rx_empty, 1);

      // Transmit gating
      tx_enable = 1'b0;
      load_tx(8'h41);
      lows = 0;
      repeat (200) begin
         clk1();
         if (tx_out == 1'b0) lows++;
      end
      chk("gate_idle", lows, 0);
      chk("gate_held", tx_empty, 0);
      tx_enable = 1'b1;
      check_tx_frame(8'h41, BITC + 4);

      // Overrun
      send_rx(8'h11, 1'b1);
      chk("ovr_first", rx_data, 8'h11);
      send_rx(8'h22, 1'b1);
      chk("ovr_data", rx_data, 8'h22);
      chk("ovr_empty", rx_empty, 0);

      // Loopback
      unload();
      chk("lb_pre_empty", rx_empty, 1);
      loop_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         load_tx(lb_bytes[k]);
         ok = 1'b0;
         for (int i = 0; i < 800; i++) begin
            if (tx_empty == 1'b1) begin
               ok = 1'b1;
               break;
            end
            clk1();
         end
         chk("lb_tx_done", ok, 1);
         clks(4);
         chk("lb_rx_empty", rx_empty, 0);
         chk("lb_rx_data", rx_data, lb_bytes[k]);
         unload();
      end
      loop_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
